// File: rtl/timer_event_logger.sv
// timer_event_logger
//   Timestamps rising edges of the interval-timer irq into a small FIFO and
//   exposes the log through an Avalon-MM slave (1-cycle registered reads).
//
// Parameters
//   DEPTH       FIFO entry count; power of two, 2..16.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   event_in    level event (timer irq), synchronous to clk
//   chipselect  slave select
//   address     register index [2:0]
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   write data [15:0]
//   readdata    registered read data [15:0]
//   irq         FIFO non-empty AND irq_en
//
// Register map
//   0 status  (R)  bit0 empty, bit1 full, bit2 overflow, bits[8:4] count.
//                  Any write clears overflow.
//   1 control (RW) bit0 irq_en, bit1 log_en; writing bit2=1 flushes the FIFO.
//   2 head timestamp[15:0]  (R, no pop)
//   3 head timestamp[31:16] (R, pops)
//   4 event_total (R)
//   5 live cycle counter[15:0] (R)
//   6 live cycle counter[31:16] (R)
//   7 reads 0
module timer_event_logger #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        event_in,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      cycle_q,     cycle_d;
    logic             event_dly_q, event_dly_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             overflow_q,  overflow_d;
    logic [15:0]      total_q,     total_d;
    logic             irq_en_q,    irq_en_d;
    logic             log_en_q,    log_en_d;
    logic [15:0]      readdata_q,  readdata_d;

    logic [31:0]      mem_q [DEPTH];

    logic        rise;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        flush;
    logic        full;
    logic        empty;
    logic        wr_sel;
    logic        rd_sel;
    logic [31:0] head_ts;
    logic [15:0] status;

    // writedata[15:3] carries no register bits.
    logic unused_wdata;
    assign unused_wdata = ^writedata[15:3];

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        wr_sel   = chipselect & ~write_n;
        rd_sel   = chipselect & ~read_n;
        rise     = event_in & ~event_dly_q;
        push_req = rise & log_en_q;
        pop      = rd_sel & (address == 3'd3) & ~empty;
        flush    = wr_sel & (address == 3'd1) & writedata[2];
        // A pop frees the slot in the same cycle, so a full FIFO still accepts
        // a push when it is being read; a flush discards any same-cycle push.
        push     = push_req & (~full | pop) & ~flush;

        head_ts  = empty ? '0 : mem_q[rd_ptr_q];

        status      = '0;
        status[0]   = empty;
        status[1]   = full;
        status[2]   = overflow_q;
        status[8:4] = 5'(count_q);

        cycle_d     = cycle_q + 32'd1;
        event_dly_d = event_in;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        total_d     = total_q;
        irq_en_d    = irq_en_q;
        log_en_d    = log_en_q;

        if (push_req) begin
            total_d = total_q + 16'd1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Clear first so a same-cycle drop leaves overflow set.
        if (wr_sel && address == 3'd0) begin
            overflow_d = 1'b0;
        end
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end

        if (wr_sel && address == 3'd1) begin
            irq_en_d = writedata[0];
            log_en_d = writedata[1];
        end

        // Mux reflects pre-update state, so a popping read returns the old head.
        case (address)
            3'd0:    readdata_d = status;
            3'd1:    readdata_d = {14'd0, log_en_q, irq_en_q};
            3'd2:    readdata_d = head_ts[15:0];
            3'd3:    readdata_d = head_ts[31:16];
            3'd4:    readdata_d = total_q;
            3'd5:    readdata_d = cycle_q[15:0];
            3'd6:    readdata_d = cycle_q[31:16];
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q     <= '0;
            event_dly_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            total_q     <= '0;
            irq_en_q    <= 1'b0;
            log_en_q    <= 1'b1;
            readdata_q  <= '0;
        end else begin
            cycle_q     <= cycle_d;
            event_dly_q <= event_dly_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            total_q     <= total_d;
            irq_en_q    <= irq_en_d;
            log_en_q    <= log_en_d;
            readdata_q  <= readdata_d;
        end
    end

    // Storage needs no reset: count/pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cycle_q;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_en_q & ~empty;

endmodule

// File: tb/tb_timer_event_logger.sv
// tb_timer_event_logger
//   Scoreboard bench for timer_event_logger. Inputs change on the falling
//   edge; read results are checked on the following falling edge.
module tb_timer_event_logger;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        event_in;
    logic        chipselect;
    logic [2:0]  address;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    timer_event_logger #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .event_in   (event_in),
        .chipselect (chipselect),
        .address    (address),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset release.
    logic [31:0] edges;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= '0;
        else          edges <= edges + 32'd1;
    end

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t    sb[$];
    logic [31:0] mq[$];
    logic        ovf_m;
    logic [15:0] total_m;
    logic        irq_en_m;
    logic        log_en_m;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ovf_m    = 1'b0;
        total_m  = '0;
        irq_en_m = 1'b0;
        log_en_m = 1'b1;
    endtask

    task automatic model_rise(input logic [31:0] ts);
        if (log_en_m) begin
            total_m = total_m + 16'd1;
            if (mq.size() < DEPTH) mq.push_back(ts);
            else                   ovf_m = 1'b1;
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        logic [15:0] r;
        logic [31:0] h;
        r = '0;
        h = (mq.size() != 0) ? mq[0] : 32'd0;
        case (a)
            3'd0: begin
                r[0]   = (mq.size() == 0);
                r[1]   = (mq.size() == DEPTH);
                r[2]   = ovf_m;
                r[8:4] = 5'(mq.size());
            end
            3'd1:    r = {14'd0, log_en_m, irq_en_m};
            3'd2:    r = h[15:0];
            3'd3:    r = h[31:16];
            3'd4:    r = total_m;
            3'd5:    r = edges[15:0];
            3'd6:    r = edges[31:16];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Read one register; optionally raise event_in in the same cycle.
    task automatic rd(input string tag, input logic [2:0] a, input bit with_rise = 0);
        sb_item_t it;
        sb_item_t got;
        logic [31:0] ts;
        it.tag = tag;
        it.exp = exp_read(a);
        ts     = edges;
        chipselect = 1'b1;
        address    = a;
        read_n     = 1'b0;
        if (with_rise) event_in = 1'b1;
        if (a == 3'd3 && mq.size() != 0) void'(mq.pop_front());
        if (with_rise) model_rise(ts);
        sb.push_back(it);
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        address    = 3'd7;
        event_in   = 1'b0;
        got = sb.pop_front();
        check(got.tag, {16'd0, readdata}, {16'd0, got.exp});
        if (with_rise) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        address    = a;
        write_n    = 1'b0;
        writedata  = d;
        if (a == 3'd0) ovf_m = 1'b0;
        if (a == 3'd1) begin
            irq_en_m = d[0];
            log_en_m = d[1];
            if (d[2]) mq.delete();
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd7;
        writedata  = '0;
    endtask

    task automatic ev_rise();
        event_in = 1'b1;
        model_rise(edges);
        @(negedge clk);
        event_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_irq(input string tag);
        check(tag, {31'd0, irq}, {31'd0, irq_en_m && mq.size() != 0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        event_in   = 1'b0;
        chipselect = 1'b0;
        address    = 3'd7;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        model_reset();

        #3;
        check("rst_rdata", {16'd0, readdata}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdata", {16'd0, readdata}, 32'd0);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        // First event at cycle counter 0x64.
        while (edges < 32'h64) @(negedge clk);
        ev_rise();
        rd("t1_status", 3'd0);
        rd("t1_ts_lo", 3'd2);
        rd("t1_ts_hi_pop", 3'd3);
        rd("t1_status_empty", 3'd0);

        // Ten rises into an 8-deep FIFO with no reads.
        for (int i = 0; i < 10; i++) ev_rise();
        rd("t2_status_full", 3'd0);
        rd("t2_total", 3'd4);
        wr(3'd0, 16'h0000);
        rd("t2_status_ovf_clr", 3'd0);

        // Rise in the same cycle as a popping read on a full FIFO.
        rd("t3_pop_rise", 3'd3, 1);
        rd("t3_status", 3'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd($sformatf("t3_drain_lo%0d", i), 3'd2);
            rd($sformatf("t3_drain_hi%0d", i), 3'd3);
        end
        rd("t3_status_empty", 3'd0);

        // irq follows count and irq_en.
        ev_rise();
        ev_rise();
        wr(3'd1, 16'h0001);
        chk_irq("t4_irq_on");
        rd("t4_pop1", 3'd3);
        chk_irq("t4_irq_still");
        rd("t4_pop2", 3'd3);
        chk_irq("t4_irq_off");

        // A held level logs once; log_en=0 suppresses logging and counting.
        wr(3'd1, 16'h0003);
        event_in = 1'b1;
        model_rise(edges);
        repeat (50) @(negedge clk);
        event_in = 1'b0;
        @(negedge clk);
        rd("t5_status_one", 3'd0);
        rd("t5_total", 3'd4);
        wr(3'd1, 16'h0001);
        ev_rise();
        rd("t5_status_nolog", 3'd0);
        rd("t5_total_nolog", 3'd4);
        rd("t5_ctrl", 3'd1);

        // Flush and set log_en through control.
        wr(3'd1, 16'h0003);
        ev_rise();
        ev_rise();
        rd("t6_status_three", 3'd0);
        wr(3'd1, 16'h0006);
        chk_irq("t6_irq_flush");
        rd("t6_status_flushed", 3'd0);
        rd("t6_ctrl", 3'd1);
        rd("t6_cyc_lo", 3'd5);
        rd("t6_cyc_hi", 3'd6);
        rd("t6_addr7", 3'd7);
        wr(3'd4, 16'hFFFF);
        rd("t6_total_ro", 3'd4);

        // Reset in the middle of activity.
        wr(3'd1, 16'h0003);
        ev_rise();
        ev_rise();
        chk_irq("t7_irq_pre");
        chipselect = 1'b1;
        address    = 3'd4;
        read_n     = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("t7_rst_rdata", {16'd0, readdata}, 32'd0);
        check("t7_rst_irq", {31'd0, irq}, 32'd0);
        chipselect = 1'b0;
        read_n     = 1'b1;
        address    = 3'd7;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t7_post_rdata", {16'd0, readdata}, 32'd0);
        rd("t7_status", 3'd0);
        rd("t7_ctrl", 3'd1);
        rd("t7_total", 3'd4);
        ev_rise();
        rd("t7_status_one", 3'd0);
        rd("t7_ts_lo", 3'd2);
        rd("t7_ts_hi", 3'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
